// File: rtl/m_key_repeat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_key_repeat_pkg
//  Description : Shared state encodings and widths for the key auto-repeat block.
//  Revision    : 1.0  initial release
// ============================================================================
package m_key_repeat_pkg;

    localparam int KR_STATE_W = 2;

    // Code 2'd3 is deliberately unused and recovers to KR_IDLE.
    typedef enum logic [KR_STATE_W-1:0] {
        KR_IDLE    = 2'd0,
        KR_PRESSED = 2'd1,
        KR_REPEAT  = 2'd2
    } kr_state_e;

endpackage : m_key_repeat_pkg
`default_nettype wire

// File: rtl/m_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : m_sync2
//  Description : Two-flop level synchronizer, cleared to 0 by synchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module m_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1_q;
    logic r_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_q <= 1'b0;
            r_s2_q <= 1'b0;
        end else begin
            r_s1_q <= d;
            r_s2_q <= r_s1_q;
        end
    end

    assign q = r_s2_q;

endmodule : m_sync2
`default_nettype wire

// File: rtl/m_key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : m_key_repeat
//  Description : Press pulse plus delayed auto-repeat pulse train from a
//                debounced key level, for the time-setting counters.
//  Revision    : 1.0  initial release
// ============================================================================
module m_key_repeat
    import m_key_repeat_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sw_in,
    output logic pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    logic             w_sw_sync;
    kr_state_e        r_state_q;
    logic [CNT_W-1:0] r_cnt_q;
    logic             r_pulse_q;
    logic             r_held_q;

    m_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (w_sw_sync)
    );

    // Release or disable takes precedence over any terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= KR_IDLE;
            r_cnt_q   <= '0;
            r_pulse_q <= 1'b0;
            r_held_q  <= 1'b0;
        end else if (!en || !w_sw_sync) begin
            r_state_q <= KR_IDLE;
            r_cnt_q   <= '0;
            r_pulse_q <= 1'b0;
            r_held_q  <= 1'b0;
        end else begin
            case (r_state_q)
                KR_IDLE: begin
                    r_state_q <= KR_PRESSED;
                    r_cnt_q   <= '0;
                    r_pulse_q <= 1'b1;
                    r_held_q  <= 1'b0;
                end
                KR_PRESSED: begin
                    if (r_cnt_q == C_HOLD_LAST) begin
                        r_state_q <= KR_REPEAT;
                        r_cnt_q   <= '0;
                        r_pulse_q <= 1'b1;
                        r_held_q  <= 1'b1;
                    end else begin
                        r_cnt_q   <= r_cnt_q + C_CNT_ONE;
                        r_pulse_q <= 1'b0;
                    end
                end
                KR_REPEAT: begin
                    if (r_cnt_q == C_REPEAT_LAST) begin
                        r_cnt_q   <= '0;
                        r_pulse_q <= 1'b1;
                    end else begin
                        r_cnt_q   <= r_cnt_q + C_CNT_ONE;
                        r_pulse_q <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= KR_IDLE;
                    r_cnt_q   <= '0;
                    r_pulse_q <= 1'b0;
                    r_held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = r_pulse_q;
    assign held  = r_held_q;

endmodule : m_key_repeat
`default_nettype wire

// File: tb/tb_m_key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_key_repeat
//  Description : Self-checking bench for m_key_repeat with a run-length model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_key_repeat;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sw_in;
    logic pulse;
    logic held;

    int checks = 0;
    int errors = 0;

    // Model: s1/s2 synchronizer image and the number of consecutive edges
    // on which the key has been both enabled and (synchronized) pressed.
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;
    int m_run = 0;

    always #5 clk = ~clk;

    m_key_repeat #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sw_in (sw_in),
        .pulse (pulse),
        .held  (held)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_pulse(input int run);
        return (run == 1) || (run > HOLD && ((run - 1 - HOLD) % REPEAT) == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_run = 0;
        end else begin
            m_run = (en && m_s2) ? m_run + 1 : 0;
            m_s2  = m_s1;
            m_s1  = sw_in;
        end
        #1;
        chk("model_pulse", pulse, exp_pulse(m_run));
        chk("model_held", held, m_run > HOLD);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        sw_in = 1'b1;

        // Reset with key already down.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pulse", pulse, 1'b0);
            chk("rst_held", held, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_e1", pulse, 1'b0);
        tick();
        chk("post_rst_e2", pulse, 1'b0);
        tick();
        chk("post_rst_press", pulse, 1'b1);
        sw_in = 1'b0;
        repeat (6) tick();
        chk("idle_pulse", pulse, 1'b0);

        // Short press: single pulse, never held.
        sw_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("short_pulse", pulse, i == 2);
        end
        sw_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("short_pulse_tail", pulse, 1'b0);
            chk("short_held", held, 1'b0);
        end

        // Long press: press, then repeat at +8, +12, +16.
        sw_in = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick();
            chk("long_pulse", pulse, i == 2 || i == 10 || i == 14 || i == 18);
            chk("long_held", held, i >= 10);
        end

        // Disable mid-repeat, key still down, then re-enable.
        en = 1'b0;
        tick();
        chk("en_off_pulse", pulse, 1'b0);
        chk("en_off_held", held, 1'b0);
        tick();
        en = 1'b1;
        tick();
        chk("en_on_press", pulse, 1'b1);
        chk("en_on_held", held, 1'b0);
        repeat (7) tick();
        chk("en_pre_repeat", pulse, 1'b0);
        tick();
        chk("en_first_repeat", pulse, 1'b1);
        chk("en_first_held", held, 1'b1);

        // One-cycle release then re-press inside the hold window.
        sw_in = 1'b0;
        repeat (6) tick();
        sw_in = 1'b1;
        repeat (5) tick();
        sw_in = 1'b0;
        tick();
        sw_in = 1'b1;
        tick();
        tick();
        chk("repress_gap", pulse, 1'b0);
        tick();
        chk("repress_pulse", pulse, 1'b1);
        repeat (7) tick();
        chk("repress_no_early", pulse, 1'b0);
        tick();
        chk("repress_repeat", pulse, 1'b1);
        chk("repress_held", held, 1'b1);

        // Randomized segments checked by the model process.
        for (int n = 0; n < 250; n++) begin
            sw_in = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 7) != 0);
            rst   = ($urandom_range(0, 39) == 0);
            tick();
            rst = 1'b0;
            repeat ($urandom_range(0, 35)) tick();
        end

        sw_in = 1'b0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_m_key_repeat
`default_nettype wire
